// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-select bit positions, FSM states
// and a one-hot test used on the control word.
package alu_pkg;

   localparam int unsigned NUM_OPS = 13;

   localparam int unsigned OP_AND  = 0;
   localparam int unsigned OP_OR   = 1;
   localparam int unsigned OP_ADD  = 2;
   localparam int unsigned OP_SUB  = 3;
   localparam int unsigned OP_MUL  = 4;
   localparam int unsigned OP_DIV  = 5;
   localparam int unsigned OP_SHR  = 6;
   localparam int unsigned OP_SHRA = 7;
   localparam int unsigned OP_SHL  = 8;
   localparam int unsigned OP_ROR  = 9;
   localparam int unsigned OP_ROL  = 10;
   localparam int unsigned OP_NEG  = 11;
   localparam int unsigned OP_NOT  = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_ITER,
      ST_DONE
   } state_e;

   function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
         n += {31'b0, v[i]};
      end
      return (n == 32'd1);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus between the A/B operand registers, the ALU and the Z (C) register.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic                        start;
   logic [alu_pkg::NUM_OPS-1:0] control;
   logic [WIDTH-1:0]            A;
   logic [WIDTH-1:0]            B;
   logic [2*WIDTH-1:0]          C;
   logic                        busy;
   logic                        done;
   logic                        zero;
   logic                        carry;
   logic                        div_by_zero;
   logic                        illegal_op;

   modport master (
      output start, control, A, B,
      input  C, busy, done, zero, carry, div_by_zero, illegal_op
   );

   modport slave (
      input  start, control, A, B,
      output C, busy, done, zero, carry, div_by_zero, illegal_op
   );
endinterface

// File: rtl/alu_md_iter.sv
// Shared WIDTH-step multiply (radix-2 shift-add) / divide (restoring) engine.
// Operands are reduced to magnitudes on load and the signs are reapplied on the result.
module alu_md_iter #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   load,
   input  logic                   is_div,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   output logic [$clog2(WIDTH):0] step,
   output logic                   fin,
   output logic [2*WIDTH-1:0]     result
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               run_q, run_d, div_q, div_d;
   logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic [WIDTH:0]     mul_sum, div_shift, div_trial;
   logic [WIDTH-1:0]   hi, lo;

   assign neg_a = SIGNED && a[WIDTH-1];
   assign neg_b = SIGNED && b[WIDTH-1];
   assign mag_a = neg_a ? -a : a;
   assign mag_b = neg_b ? -b : b;
   assign hi    = acc_q[2*WIDTH-1:WIDTH];
   assign lo    = acc_q[WIDTH-1:0];

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      div_d     = div_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi, lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      if (load) begin
         acc_d    = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
         opnd_d   = is_div ? mag_b : mag_a;
         cnt_d    = '0;
         run_d    = 1'b1;
         div_d    = is_div;
         neg_lo_d = neg_a ^ neg_b;
         neg_hi_d = neg_a;
      end else if (run_q) begin
         if (cnt_q == CW'(WIDTH)) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (!div_q)
               acc_d = {mul_sum, lo[WIDTH-1:1]};
            else if (!div_trial[WIDTH])
               acc_d = {div_trial[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
            else
               acc_d = {div_shift[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         acc_q    <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         div_q    <= div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
      end
   end

   assign step   = cnt_q;
   assign fin    = run_q && (cnt_q == CW'(WIDTH));
   assign result = div_q ? {neg_hi_q ? -hi : hi, neg_lo_q ? -lo : lo}
                         : (neg_lo_q ? -acc_q : acc_q);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops are computed from the captured operands in EXEC,
// MUL and nonzero-divisor DIV run through the shared iterative engine in ITER.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input logic      clock,
   input logic      clear,
   alu_seq_if.slave bus
);
   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = SW + 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [NUM_OPS-1:0] ctrl_q, ctrl_d;
   logic [2*WIDTH-1:0] c_q, c_d;
   logic               zero_q, zero_d, carry_q, carry_d;
   logic               dbz_q, dbz_d, ill_q, ill_d;

   logic               md_load, md_fin;
   logic [CW-1:0]      md_step;
   logic [2*WIDTH-1:0] md_result;

   logic [2*WIDTH-1:0] sc_c;
   logic               sc_carry, sc_dbz, sc_ill;
   logic [SW-1:0]      s;
   logic [CW-1:0]      s_inv;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   shra;

   alu_md_iter #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_md (
      .clock  (clock),
      .clear  (clear),
      .load   (md_load),
      .is_div (bus.control[OP_DIV]),
      .a      (bus.A),
      .b      (bus.B),
      .step   (md_step),
      .fin    (md_fin),
      .result (md_result)
   );

   always_comb begin
      s        = b_q[SW-1:0];
      s_inv    = CW'(WIDTH) - {1'b0, s};
      sum      = {1'b0, a_q} + {1'b0, b_q};
      shra     = $signed(a_q) >>> s;
      sc_c     = '0;
      sc_carry = 1'b0;
      sc_dbz   = 1'b0;
      sc_ill   = 1'b0;
      if (!is_onehot(ctrl_q)) begin
         sc_ill = 1'b1;
      end else begin
         case (1'b1)
            ctrl_q[OP_AND]:  sc_c[WIDTH-1:0] = a_q & b_q;
            ctrl_q[OP_OR]:   sc_c[WIDTH-1:0] = a_q | b_q;
            ctrl_q[OP_ADD]:  begin sc_c[WIDTH:0] = sum; sc_carry = sum[WIDTH]; end
            ctrl_q[OP_SUB]:  begin sc_c[WIDTH-1:0] = a_q - b_q; sc_carry = (a_q >= b_q); end
            // only a zero divisor reaches EXEC for DIV
            ctrl_q[OP_DIV]:  begin sc_c = {a_q, {WIDTH{1'b1}}}; sc_dbz = 1'b1; end
            ctrl_q[OP_SHR]:  sc_c[WIDTH-1:0] = a_q >> s;
            ctrl_q[OP_SHRA]: sc_c[WIDTH-1:0] = shra;
            ctrl_q[OP_SHL]:  sc_c[WIDTH-1:0] = a_q << s;
            ctrl_q[OP_ROR]:  sc_c[WIDTH-1:0] = (a_q >> s) | (a_q << s_inv);
            ctrl_q[OP_ROL]:  sc_c[WIDTH-1:0] = (a_q << s) | (a_q >> s_inv);
            ctrl_q[OP_NEG]:  sc_c[WIDTH-1:0] = (~b_q) + 1'b1;
            ctrl_q[OP_NOT]:  sc_c[WIDTH-1:0] = ~b_q;
            default:         sc_c = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      c_d     = c_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      dbz_d   = dbz_q;
      ill_d   = ill_q;
      md_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d    = bus.A;
               b_d    = bus.B;
               ctrl_d = bus.control;
               if (is_onehot(bus.control) &&
                   (bus.control[OP_MUL] || (bus.control[OP_DIV] && bus.B != '0))) begin
                  state_d = ST_ITER;
                  md_load = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            c_d     = sc_c;
            zero_d  = (sc_c[WIDTH-1:0] == '0);
            carry_d = sc_carry;
            dbz_d   = sc_dbz;
            ill_d   = sc_ill;
         end
         ST_ITER: begin
            if (md_fin && md_step == CW'(WIDTH)) begin
               state_d = ST_DONE;
               c_d     = md_result;
               zero_d  = ctrl_q[OP_MUL] ? (md_result == '0) : (md_result[WIDTH-1:0] == '0);
               carry_d = 1'b0;
               dbz_d   = 1'b0;
               ill_d   = 1'b0;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         c_q     <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         dbz_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         c_q     <= c_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         dbz_q   <= dbz_d;
         ill_q   <= ill_d;
      end
   end

   assign bus.C           = c_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.zero        = zero_q;
   assign bus.carry       = carry_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.illegal_op  = ill_q;

endmodule
